// File: rtl/cu_pkg.sv
// Shared types and encodings for the multi-cycle RV32I-subset control unit.
package cu_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WR   = 4'd6,
    WB_ALU   = 4'd7,
    WB_MEM   = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    LUI      = 4'd11,
    TRAP     = 4'd12
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic       ADDR_PC       = 1'b0;
  localparam logic       ADDR_ALUOUT   = 1'b1;
  localparam logic       PC_SRC_ALU    = 1'b0;
  localparam logic       PC_SRC_ALUOUT = 1'b1;

  localparam logic [1:0] SRC_A_PC    = 2'd0;
  localparam logic [1:0] SRC_A_OLDPC = 2'd1;
  localparam logic [1:0] SRC_A_RS1   = 2'd2;

  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [1:0] RES_ALUOUT  = 2'd0;
  localparam logic [1:0] RES_MEMDATA = 2'd1;
  localparam logic [1:0] RES_PC      = 2'd2;
  localparam logic [1:0] RES_IMM     = 2'd3;

  localparam logic [1:0] CAUSE_NONE        = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL     = 2'd1;
  localparam logic [1:0] CAUSE_MEM_TIMEOUT = 2'd2;

  // Control bundle driven toward the datapath each cycle.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_src;
    logic       ir_we;
    logic       pc_we;
    logic       pc_src;
    logic       reg_we;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    alu_op_e    alu_op;
    logic [2:0] imm_sel;
    logic [1:0] result_src;
  } ctrl_t;

  // States that stall on the shared memory port.
  function automatic logic is_mem_wait(input state_e s);
    return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

  // States whose exit to FETCH completes an instruction.
  function automatic logic is_retiring(input state_e s);
    return (s == MEM_WR) || (s == WB_ALU) || (s == WB_MEM) ||
           (s == BRANCH) || (s == JAL) || (s == LUI);
  endfunction

endpackage

// File: rtl/cu_alu_dec.sv
// ALU operation decoder for R-type and I-type arithmetic instructions.
module cu_alu_dec
  import cu_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       is_rtype,
  output alu_op_e    alu_op
);

  // funct7[5] selects SUB only for register-register ops; for shifts it selects SRA
  always_comb begin
    alu_op = ALU_ADD;
    case (funct3)
      3'b000:  alu_op = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  end

endmodule

// File: rtl/cu_multicycle.sv
// Multi-cycle control unit: sequences fetch/decode/execute/memory/write-back,
// with memory timeout and illegal-opcode trapping and a retired-instruction counter.
module cu_multicycle
  import cu_pkg::*;
#(
  parameter int unsigned ALUOP_W     = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instr,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               addr_src,
  output logic               ir_we,
  output logic               pc_we,
  output logic               pc_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [2:0]         imm_sel,
  output logic [1:0]         result_src,
  output logic               reg_we,
  output logic               trap,
  output logic [1:0]         trap_cause,
  output logic [3:0]         state_o,
  output logic [CNT_W-1:0]   instret
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

  state_e             state_q, state_d;
  ctrl_t              ctrl;
  alu_op_e            dec_op;
  logic [1:0]         cause_q, cause_d;
  logic               trap_q;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]   instret_q;
  logic               wait_last;
  logic               retire;
  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic               unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  // Final permitted stall cycle; a miss here times out, a hit still wins.
  assign wait_last = (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
  assign retire    = (state_d == FETCH) && is_retiring(state_q);

  cu_alu_dec u_alu_dec (
    .funct3   (funct3),
    .funct7_5 (instr[30]),
    .is_rtype (state_q == EXEC_R),
    .alu_op   (dec_op)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= FETCH;
      wait_cnt  <= '0;
      trap_q    <= 1'b0;
      cause_q   <= CAUSE_NONE;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      trap_q  <= (state_d == TRAP);
      cause_q <= cause_d;
      if (state_d != state_q) begin
        wait_cnt <= '0;
      end else if (is_mem_wait(state_q) && !mem_ready) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (retire) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    ctrl         = '0;
    ctrl.alu_op  = ALU_ADD;

    case (state_q)
      FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.addr_src  = ADDR_PC;
        ctrl.alu_src_a = SRC_A_PC;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.ir_we     = mem_ready;
        ctrl.pc_we     = mem_ready;
        if (mem_ready) begin
          state_d = DECODE;
        end else if (wait_last) begin
          state_d = TRAP;
          cause_d = CAUSE_MEM_TIMEOUT;
        end
      end

      // Branch target is computed speculatively into ALUOUT while decoding.
      DECODE: begin
        ctrl.alu_src_a = SRC_A_OLDPC;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.imm_sel   = IMM_B;
        case (opcode)
          OP_R:              state_d = EXEC_R;
          OP_I:              state_d = EXEC_I;
          OP_LOAD, OP_STORE: state_d = MEM_ADDR;
          OP_JAL:            state_d = JAL;
          OP_LUI:            state_d = LUI;
          OP_BRANCH: begin
            if (funct3 == 3'b000 || funct3 == 3'b001) begin
              state_d = BRANCH;
            end else begin
              state_d = TRAP;
              cause_d = CAUSE_ILLEGAL;
            end
          end
          default: begin
            state_d = TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end

      EXEC_R: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_RS2;
        ctrl.alu_op    = dec_op;
        state_d        = WB_ALU;
      end

      EXEC_I: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.imm_sel   = IMM_I;
        ctrl.alu_op    = dec_op;
        state_d        = WB_ALU;
      end

      MEM_ADDR: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.imm_sel   = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_d        = (opcode == OP_STORE) ? MEM_WR : MEM_RD;
      end

      MEM_RD: begin
        ctrl.mem_req  = 1'b1;
        ctrl.addr_src = ADDR_ALUOUT;
        if (mem_ready) begin
          state_d = WB_MEM;
        end else if (wait_last) begin
          state_d = TRAP;
          cause_d = CAUSE_MEM_TIMEOUT;
        end
      end

      MEM_WR: begin
        ctrl.mem_req  = 1'b1;
        ctrl.mem_we   = 1'b1;
        ctrl.addr_src = ADDR_ALUOUT;
        if (mem_ready) begin
          state_d = FETCH;
        end else if (wait_last) begin
          state_d = TRAP;
          cause_d = CAUSE_MEM_TIMEOUT;
        end
      end

      WB_ALU: begin
        ctrl.reg_we     = 1'b1;
        ctrl.result_src = RES_ALUOUT;
        state_d         = FETCH;
      end

      WB_MEM: begin
        ctrl.reg_we     = 1'b1;
        ctrl.result_src = RES_MEMDATA;
        state_d         = FETCH;
      end

      // funct3[0] inverts the sense of zero: BEQ takes on zero, BNE on non-zero.
      BRANCH: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_RS2;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PC_SRC_ALUOUT;
        ctrl.pc_we     = zero ^ funct3[0];
        state_d        = FETCH;
      end

      JAL: begin
        ctrl.imm_sel    = IMM_J;
        ctrl.alu_src_a  = SRC_A_OLDPC;
        ctrl.alu_src_b  = SRC_B_IMM;
        ctrl.pc_src     = PC_SRC_ALU;
        ctrl.pc_we      = 1'b1;
        ctrl.reg_we     = 1'b1;
        ctrl.result_src = RES_PC;
        state_d         = FETCH;
      end

      LUI: begin
        ctrl.imm_sel    = IMM_U;
        ctrl.reg_we     = 1'b1;
        ctrl.result_src = RES_IMM;
        state_d         = FETCH;
      end

      TRAP: state_d = TRAP;

      default: state_d = FETCH;
    endcase

    // While reset is held no request or write may reach memory or the register file.
    if (!reset) begin
      ctrl.mem_req = 1'b0;
      ctrl.mem_we  = 1'b0;
      ctrl.ir_we   = 1'b0;
      ctrl.pc_we   = 1'b0;
      ctrl.reg_we  = 1'b0;
    end
  end

  assign mem_req    = ctrl.mem_req;
  assign mem_we     = ctrl.mem_we;
  assign addr_src   = ctrl.addr_src;
  assign ir_we      = ctrl.ir_we;
  assign pc_we      = ctrl.pc_we;
  assign pc_src     = ctrl.pc_src;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ALUOP_W'(ctrl.alu_op);
  assign imm_sel    = ctrl.imm_sel;
  assign result_src = ctrl.result_src;
  assign reg_we     = ctrl.reg_we;
  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign state_o    = state_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_cu_multicycle.sv
// Scoreboard bench for cu_multicycle: per-cycle expected control vectors are queued
// by the stimulus and checked by an independent negedge monitor.
module tb_cu_multicycle;

  localparam int S_FETCH = 0, S_DEC = 1, S_EXR = 2, S_EXI = 3, S_MA = 4, S_MRD = 5;
  localparam int S_MWR = 6, S_WBA = 7, S_WBM = 8, S_BR = 9, S_JAL = 10, S_LUI = 11, S_TRAP = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, addr_src, ir_we, pc_we, pc_src, reg_we, trap;
  logic [1:0]  alu_src_a, alu_src_b, result_src, trap_cause;
  logic [3:0]  alu_op, state_o, instret;
  logic [2:0]  imm_sel;

  typedef struct {
    string       tag;
    logic [30:0] vec;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] cur_ins;

  cu_multicycle #(.ALUOP_W(4), .CNT_W(4), .MEM_TIMEOUT(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .addr_src   (addr_src),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .imm_sel    (imm_sel),
    .result_src (result_src),
    .reg_we     (reg_we),
    .trap       (trap),
    .trap_cause (trap_cause),
    .state_o    (state_o),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  // Monitor: every cycle with a queued expectation is compared mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t        e;
      logic [30:0] obs;
      e   = q.pop_front();
      obs = {state_o, mem_req, mem_we, addr_src, ir_we, pc_we, pc_src, reg_we,
             alu_src_a, alu_src_b, alu_op, imm_sel, result_src, trap, trap_cause, instret};
      total = total + 1;
      if (obs !== e.vec) begin
        bad = bad + 1;
        $display("FAIL %s: got st=%0d vec=%h, expected st=%0d vec=%h",
                 e.tag, obs[30:27], obs, e.vec[30:27], e.vec);
      end
    end
  end

  // en = {mem_req, mem_we, addr_src, ir_we, pc_we, pc_src, reg_we}
  task automatic step(input string tag, input logic rdy, input logic z, input int st,
                      input logic [6:0] en, input int a, input int b, input int op,
                      input int imm, input int res, input int trp, input int cs, input int ir);
    exp_t e;
    mem_ready = rdy;
    zero      = z;
    instr     = cur_ins;
    e.tag = tag;
    e.vec = {4'(st), en, 2'(a), 2'(b), 4'(op), 3'(imm), 2'(res), 1'(trp), 2'(cs), 4'(ir)};
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_ok(input string tag, input int ir);
    step(tag, 1'b1, 1'b0, S_FETCH, 7'b1001100, 0, 2, 0, 0, 0, 0, 0, ir);
  endtask

  task automatic fetch_wait(input string tag, input int ir);
    step(tag, 1'b0, 1'b0, S_FETCH, 7'b1000000, 0, 2, 0, 0, 0, 0, 0, ir);
  endtask

  task automatic decode(input string tag, input int ir);
    step(tag, 1'b0, 1'b0, S_DEC, 7'b0000000, 1, 1, 0, 2, 0, 0, 0, ir);
  endtask

  task automatic wb_alu(input string tag, input int ir);
    step(tag, 1'b0, 1'b0, S_WBA, 7'b0000001, 0, 0, 0, 0, 0, 0, 0, ir);
  endtask

  task automatic lui_cyc(input string tag, input int ir);
    step(tag, 1'b0, 1'b0, S_LUI, 7'b0000001, 0, 0, 0, 4, 3, 0, 0, ir);
  endtask

  task automatic trap_cyc(input string tag, input int cs, input int ir);
    step(tag, 1'b0, 1'b0, S_TRAP, 7'b0000000, 0, 0, 0, 0, 0, 1, cs, ir);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset     = 1'b0;
    mem_ready = 1'b0;
    zero      = 1'b0;
    instr     = '0;
    cur_ins   = '0;
    do_reset();

    // add x3,x1,x2
    cur_ins = 32'h002081B3;
    fetch_ok("add_fetch", 0);
    decode("add_dec", 0);
    step("add_exec", 1'b0, 1'b0, S_EXR, 7'b0000000, 2, 0, 0, 0, 0, 0, 0, 0);
    wb_alu("add_wb", 0);

    // lw x3,0(x1), ready on the third MEM_RD cycle
    cur_ins = 32'h0000A183;
    fetch_ok("lw_fetch", 1);
    decode("lw_dec", 1);
    step("lw_addr", 1'b0, 1'b0, S_MA, 7'b0000000, 2, 1, 0, 0, 0, 0, 0, 1);
    step("lw_rd1", 1'b0, 1'b0, S_MRD, 7'b1010000, 0, 0, 0, 0, 0, 0, 0, 1);
    step("lw_rd2", 1'b0, 1'b0, S_MRD, 7'b1010000, 0, 0, 0, 0, 0, 0, 0, 1);
    step("lw_rd3", 1'b1, 1'b0, S_MRD, 7'b1010000, 0, 0, 0, 0, 0, 0, 0, 1);
    step("lw_wb", 1'b0, 1'b0, S_WBM, 7'b0000001, 0, 0, 0, 0, 1, 0, 0, 1);

    // beq taken / not taken, bne taken
    cur_ins = 32'h00208463;
    fetch_ok("beq1_fetch", 2);
    decode("beq1_dec", 2);
    step("beq_taken", 1'b0, 1'b1, S_BR, 7'b0000110, 2, 0, 1, 0, 0, 0, 0, 2);
    fetch_ok("beq0_fetch", 3);
    decode("beq0_dec", 3);
    step("beq_not_taken", 1'b0, 1'b0, S_BR, 7'b0000010, 2, 0, 1, 0, 0, 0, 0, 3);
    cur_ins = 32'h00209463;
    fetch_ok("bne_fetch", 4);
    decode("bne_dec", 4);
    step("bne_taken", 1'b0, 1'b0, S_BR, 7'b0000110, 2, 0, 1, 0, 0, 0, 0, 4);

    // srai -> SRA, sub -> SUB, addi with instr[30]=1 -> still ADD
    cur_ins = 32'h4030D193;
    fetch_ok("srai_fetch", 5);
    decode("srai_dec", 5);
    step("srai_exec", 1'b0, 1'b0, S_EXI, 7'b0000000, 2, 1, 8, 0, 0, 0, 0, 5);
    wb_alu("srai_wb", 5);
    cur_ins = 32'h402081B3;
    fetch_ok("sub_fetch", 6);
    decode("sub_dec", 6);
    step("sub_exec", 1'b0, 1'b0, S_EXR, 7'b0000000, 2, 0, 1, 0, 0, 0, 0, 6);
    wb_alu("sub_wb", 6);
    cur_ins = 32'hC0008193;
    fetch_ok("addi_fetch", 7);
    decode("addi_dec", 7);
    step("addi_exec", 1'b0, 1'b0, S_EXI, 7'b0000000, 2, 1, 0, 0, 0, 0, 0, 7);
    wb_alu("addi_wb", 7);

    // jal, lui, sw
    cur_ins = 32'h0000006F;
    fetch_ok("jal_fetch", 8);
    decode("jal_dec", 8);
    step("jal_exec", 1'b0, 1'b0, S_JAL, 7'b0000101, 1, 1, 0, 3, 2, 0, 0, 8);
    cur_ins = 32'h12345037;
    fetch_ok("lui_fetch", 9);
    decode("lui_dec", 9);
    lui_cyc("lui_exec", 9);
    cur_ins = 32'h0020A023;
    fetch_ok("sw_fetch", 10);
    decode("sw_dec", 10);
    step("sw_addr", 1'b0, 1'b0, S_MA, 7'b0000000, 2, 1, 0, 1, 0, 0, 0, 10);
    step("sw_wr", 1'b1, 1'b0, S_MWR, 7'b1110000, 0, 0, 0, 0, 0, 0, 0, 10);

    // Fetch never ready: 8 stalled cycles then memory-timeout trap
    cur_ins = 32'h12345037;
    for (int i = 0; i < 8; i++) fetch_wait("to_stall", 11);
    trap_cyc("to_trap_a", 2, 11);
    trap_cyc("to_trap_b", 2, 11);
    do_reset();

    // Ready arrives on the 8th cycle: no trap
    for (int i = 0; i < 7; i++) fetch_wait("edge_stall", 0);
    fetch_ok("edge_ready", 0);
    decode("edge_dec", 0);
    lui_cyc("edge_lui", 0);

    // Illegal opcode traps and holds; instret frozen
    cur_ins = 32'h0000007F;
    fetch_ok("ill_fetch", 1);
    decode("ill_dec", 1);
    for (int i = 0; i < 10; i++) trap_cyc("ill_hold", 1, 1);
    do_reset();

    // Branch with unsupported funct3 is illegal
    cur_ins = 32'h0020A063;
    fetch_ok("illbr_fetch", 0);
    decode("illbr_dec", 0);
    trap_cyc("illbr_trap", 1, 0);
    do_reset();

    // Reset during a stalled store drops the request and clears instret
    cur_ins = 32'h12345037;
    fetch_ok("pre_fetch", 0);
    decode("pre_dec", 0);
    lui_cyc("pre_lui", 0);
    cur_ins = 32'h0020A023;
    fetch_ok("rw_fetch", 1);
    decode("rw_dec", 1);
    step("rw_addr", 1'b0, 1'b0, S_MA, 7'b0000000, 2, 1, 0, 1, 0, 0, 0, 1);
    reset = 1'b0;
    step("rw_wr_in_reset", 1'b0, 1'b0, S_MWR, 7'b0010000, 0, 0, 0, 0, 0, 0, 0, 1);
    step("rw_fetch_in_reset", 1'b0, 1'b0, S_FETCH, 7'b0000000, 0, 2, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;

    // 16 retirements wrap the 4-bit counter back to zero
    cur_ins = 32'h12345037;
    for (int i = 0; i < 16; i++) begin
      fetch_ok("wrap_fetch", i);
      decode("wrap_dec", i);
      lui_cyc("wrap_lui", i);
    end
    fetch_ok("wrap_zero", 0);

    @(negedge clk);
    #1;
    total = total + 1;
    if (q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cu_multicycle.md
Name: cu_multicycle

Overview:
Parametrised multi-cycle control unit, successor to the single-cycle `cu`, for the RV32I-subset processor. A Moore/Mealy FSM sequences fetch, decode, execute, memory and write-back over several cycles with a shared memory port. It adds memory-ready handshaking with timeout, illegal-opcode trapping and a retired-instruction counter. It sits beside the datapath: the datapath supplies IR and ALU zero, and this block drives all mux selects and write enables.

Parameters:
ALUOP_W, 4, width of alu_op
CNT_W, 32, width of instret counter
MEM_TIMEOUT, 16, max cycles waiting for mem_ready before trap (must be ≥1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset (reset=0 resets on the next clk edge)
instr  in  32  IR contents; valid from DECODE onward
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request
mem_we  out  1  memory write
addr_src  out  1  memory address: 0=PC, 1=ALUOUT
ir_we  out  1  IR and OLDPC write
pc_we  out  1  PC write
pc_src  out  1  0=ALU result, 1=ALUOUT register
alu_src_a  out  2  0=PC, 1=OLDPC, 2=RS1
alu_src_b  out  2  0=RS2, 1=IMM, 2=constant 4
alu_op  out  ALUOP_W  ALU operation
imm_sel  out  3  0=I, 1=S, 2=B, 3=J, 4=U
result_src  out  2  0=ALUOUT, 1=MEMDATA, 2=PC (PC+4 of current instr), 3=IMM
reg_we  out  1  register file write
trap  out  1  sticky trap flag
trap_cause  out  2  0=none, 1=illegal instruction, 2=memory timeout
state_o  out  4  current state encoding
instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (reset=0 at edge): state←FETCH, instret←0, wait counter←0, trap←0, trap_cause←0. This takes priority over everything, including an outstanding mem_req; the memory must tolerate a dropped request.
- Defaults in every state: all enables 0, selects 0, alu_op=ADD.
- FETCH: mem_req=1, addr_src=0, a=PC, b=4, ADD. ir_we=pc_we=mem_ready (Mealy). mem_ready=1 → DECODE; otherwise stay.
- DECODE: a=OLDPC, b=IMM, imm_sel=B, ADD (branch target into ALUOUT). Next state by opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 or 0100011 → MEM_ADDR
  - 1100011 → BRANCH; funct3 must be 000 or 001, otherwise illegal
  - 1101111 → JAL
  - 0110111 → LUI
  - anything else → TRAP, cause=1
- EXEC_R: a=RS1, b=RS2, alu_op from cu_alu_dec → WB_ALU.
- EXEC_I: a=RS1, b=IMM, imm_sel=I, alu_op from cu_alu_dec → WB_ALU.
- MEM_ADDR: a=RS1, b=IMM, imm_sel=I for loads / S for stores, ADD → MEM_RD (load) or MEM_WR (store).
- MEM_RD: mem_req=1, addr_src=1; mem_ready → WB_MEM.
- MEM_WR: mem_req=1, mem_we=1, addr_src=1; mem_ready → FETCH (retires).
- WB_ALU: reg_we=1, result_src=0 → FETCH (retires).
- WB_MEM: reg_we=1, result_src=1 → FETCH (retires).
- BRANCH: a=RS1, b=RS2, SUB, pc_src=1, pc_we=zero^funct3[0] → FETCH (retires).
- JAL: imm_sel=J, a=OLDPC, b=IMM, ADD, pc_src=0, pc_we=1, reg_we=1, result_src=2 → FETCH (retires).
- LUI: imm_sel=U, reg_we=1, result_src=3 → FETCH (retires).
- TRAP: all enables 0, trap=1; holds until reset. instret frozen.
- Wait counter:
  - counts cycles in FETCH/MEM_RD/MEM_WR with mem_ready=0; cleared on any state change;
  - reaching MEM_TIMEOUT without ready → TRAP, cause=2;
  - mem_ready in the same cycle the count reaches the limit → ready wins (no trap).
- instret increments by 1 on each transition into FETCH from a retiring state, and wraps modulo 2^CNT_W.
- Instructions take 3 cycles minimum (BRANCH/JAL/LUI) with zero-wait memory; ALU ops take 4, loads 5.

Decomposition:
- Package cu_pkg holds:
  - state enum, 4 bits: FETCH=0, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JAL, LUI, TRAP=12;
  - opcode constants;
  - alu_op codes: ADD0 SUB1 AND2 OR3 XOR4 SLT5 SLL6 SRL7 SRA8 SLTU9;
  - select encodings and trap causes.
- Sub-module cu_alu_dec is combinational: funct3, funct7[5], is_rtype → alu_op. SUB only for R-type with funct7[5]=1; SRA for funct3=101 with funct7[5]=1.

Test Plan:
- add x3,x1,x2 (0x002081B3), mem_ready=1 in FETCH → states 0,1,2,7; alu_op=0 in EXEC_R; reg_we=1 in WB_ALU; instret 0→1.
- lw x3,0(x1) (0x0000A183), mem_ready asserted on the 3rd MEM_RD cycle → MEM_RD lasts 3 cycles with mem_req=1, addr_src=1; WB_MEM has result_src=1; no trap.
- beq (0x00208463) with zero=1 → pc_we=1, pc_src=1 in BRANCH; same with zero=0 → pc_we=0; bne (funct3=001) with zero=0 → pc_we=1.
- instr=0x0000007F → DECODE→TRAP; trap=1, trap_cause=1 held 10 cycles; instret unchanged; cleared only by reset=0.
- MEM_TIMEOUT=8, mem_ready held 0 in FETCH → TRAP after 8 cycles, cause=2. Repeat with mem_ready on the 8th cycle → DECODE, no trap.
- reset=0 asserted during MEM_WR → next edge state=FETCH, mem_req=mem_we=0, instret=0. CNT_W=4 with 16 retired instructions → instret wraps to 0.
